// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding fetch with a fixed response latency,
// plus a side-band program-load write port into the word storage.
module imem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        busy
);

  localparam int Lat = (LATENCY < 1) ? 1 : ((LATENCY > 4) ? 4 : LATENCY);
  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LimitAddr = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [31:0]     data_q;
  logic            err_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept;
  logic            req_bad;
  logic            load_bad;
  logic [IdxW-1:0] req_idx;
  logic [IdxW-1:0] load_idx;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ({1'b0, a} >= LimitAddr);
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [31:0] a);
    return IdxW'((a - BASE_ADDR) >> 2);
  endfunction

  assign req_bad  = addr_bad(req_addr);
  assign load_bad = addr_bad(load_addr);
  assign req_idx  = word_idx(req_addr);
  assign load_idx = word_idx(load_addr);
  assign accept   = req_valid && req_ready;

  // Storage is deliberately outside reset so a reset never disturbs a loaded program.
  always_ff @(posedge clock) begin
    if (load_en && !load_bad) begin
      mem[load_idx] <= load_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Read happens before the same-edge load lands, so a colliding load returns the old word.
      if (accept) begin
        err_q  <= req_bad;
        data_q <= req_bad ? 32'h0 : mem[req_idx];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (Lat == 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = 2'(Lat - 1);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    rsp_valid = (state_q == StResp);
    rsp_data  = rsp_valid ? data_q : 32'h0;
    rsp_err   = rsp_valid && err_q;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: four builds (LATENCY 1, 2, 4 and an out-of-range 9) share one
// stimulus stream and are checked every cycle against a transaction-level model.
module tb_imem_responder;

  localparam logic [31:0] Base   = 32'h0100_0000;
  localparam int          Depth  = 1024;
  localparam int          NInst  = 4;
  localparam int          NWords = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] load_addr = 32'h0;
  logic [31:0] load_data = 32'h0;

  logic [NInst-1:0] req_ready, rsp_valid, rsp_err, busy;
  logic [31:0]      rsp_data [NInst];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  function automatic int raw_lat(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 4 : 9;
  endfunction

  function automatic int lat_of(input int i);
    int r;
    r = raw_lat(i);
    return (r < 1) ? 1 : (r > 4) ? 4 : r;
  endfunction

  for (genvar g = 0; g < NInst; g++) begin : g_dut
    imem_responder #(
      .BASE_ADDR  (Base),
      .DEPTH_WORDS(Depth),
      .LATENCY    (raw_lat(g))
    ) u_dut (
      .clock    (clock),
      .reset    (reset),
      .req_valid(req_valid),
      .req_ready(req_ready[g]),
      .req_addr (req_addr),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready),
      .rsp_data (rsp_data[g]),
      .rsp_err  (rsp_err[g]),
      .load_en  (load_en),
      .load_addr(load_addr),
      .load_data(load_data),
      .busy     (busy[g])
    );
  end

  // ---------------- transaction-level model ----------------
  logic [NInst-1:0] m_pend;
  logic [NInst-1:0] m_err;
  int               m_age  [NInst];
  logic [31:0]      m_data [NInst];
  logic [31:0]      m_mem  [Depth];

  function automatic logic bad(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (a[1:0] != 2'b00) || (la < longint'(Base)) || (la >= longint'(Base) + 4 * Depth);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - Base) >> 2);
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pend <= '0;
    end else begin
      for (int i = 0; i < NInst; i++) begin
        if (m_pend[i]) begin
          if (m_age[i] >= lat_of(i) && rsp_ready) m_pend[i] <= 1'b0;
          else m_age[i] <= m_age[i] + 1;
        end else if (req_valid) begin
          m_pend[i] <= 1'b1;
          m_age[i]  <= 1;
          m_err[i]  <= bad(req_addr);
          m_data[i] <= bad(req_addr) ? 32'h0 : m_mem[widx(req_addr)];
        end
      end
      if (load_en && !bad(load_addr)) m_mem[widx(load_addr)] <= load_data;
    end
  end

  function automatic logic exp_v(input int i);
    return m_pend[i] && (m_age[i] >= lat_of(i));
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h want %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < NInst; i++) begin
      chk("cmp_rsp_valid", i, 32'(rsp_valid[i]), 32'(exp_v(i)));
      chk("cmp_rsp_data", i, rsp_data[i], exp_v(i) ? m_data[i] : 32'h0);
      chk("cmp_rsp_err", i, 32'(rsp_err[i]), 32'(exp_v(i) && m_err[i]));
      chk("cmp_busy", i, 32'(busy[i]), 32'(m_pend[i]));
      chk("cmp_req_ready", i, 32'(req_ready[i]), 32'(!m_pend[i]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(&req_ready) && n < 20) begin
      tick();
      n++;
    end
    if (!(&req_ready)) begin
      checks++;
      errors++;
      $display("FAIL wait_idle req_ready got %b want all ones", req_ready);
    end
  endtask

  function automatic logic [31:0] word_init(input int k);
    if (k == 0) return 32'h0000_0093;
    if (k == 2) return 32'h1111_1111;
    return 32'hA500_0000 | 32'(k);
  endfunction

  // One-cycle request with rsp_ready held high; pins latency, data and err literally.
  task automatic fetch_check(input string name, input logic [31:0] addr,
                             input logic [31:0] exp_d, input logic exp_e, input logic ld,
                             input logic [31:0] ld_a, input logic [31:0] ld_d);
    logic [NInst-1:0] seen;
    wait_idle();
    req_valid = 1'b1;
    req_addr  = addr;
    rsp_ready = 1'b1;
    load_en   = ld;
    load_addr = ld_a;
    load_data = ld_d;
    tick();
    req_valid = 1'b0;
    load_en   = 1'b0;
    seen      = '0;
    for (int k = 1; k <= 8; k++) begin
      for (int i = 0; i < NInst; i++) begin
        if (!seen[i] && rsp_valid[i]) begin
          seen[i] = 1'b1;
          chk({name, "_lat"}, i, 32'(k), 32'(lat_of(i)));
          chk({name, "_data"}, i, rsp_data[i], exp_d);
          chk({name, "_err"}, i, 32'(rsp_err[i]), 32'(exp_e));
        end
      end
      if (&seen) break;
      tick();
    end
    for (int i = 0; i < NInst; i++) begin
      if (!seen[i]) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout inst%0d got no response want one", name, i);
      end
    end
  endtask

  function automatic logic [31:0] rand_fetch_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return Base + 32'(4 * $urandom_range(0, NWords - 1));
    if (r == 7) return Base + 32'(4 * $urandom_range(0, NWords - 1)) + 32'($urandom_range(1, 3));
    if (r == 8) begin
      case ($urandom_range(0, 2))
        0: return Base - 32'd4;
        1: return Base + 32'(4 * Depth);
        default: return 32'hFFFF_FFFC;
      endcase
    end
    return $urandom | 32'h8000_0000;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < NInst; i++) begin
      chk("rst_req_ready", i, 32'(req_ready[i]), 32'd1);
      chk("rst_busy", i, 32'(busy[i]), 32'd0);
      chk("rst_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
      chk("rst_rsp_data", i, rsp_data[i], 32'h0);
    end
    reset = 1'b1;

    for (int k = 0; k < NWords; k++) begin
      tick();
      load_en   = 1'b1;
      load_addr = Base + 32'(4 * k);
      load_data = word_init(k);
    end
    tick();
    load_addr = Base + 32'(4 * (Depth - 1));
    load_data = 32'h5A5A_0FFC;
    tick();
    load_addr = Base + 32'd1;          // misaligned: must be ignored
    load_data = 32'hDEAD_BEEF;
    tick();
    load_addr = Base + 32'(4 * Depth); // out of range: must be ignored
    tick();
    load_en = 1'b0;

    // Basic fetch under backpressure.
    wait_idle();
    req_valid = 1'b1;
    req_addr  = Base;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("l1_valid", 0, 32'(rsp_valid[0]), 32'd1);
    chk("l2_early", 1, 32'(rsp_valid[1]), 32'd0);
    tick();
    chk("l2_valid", 1, 32'(rsp_valid[1]), 32'd1);
    chk("l2_data", 1, rsp_data[1], 32'h0000_0093);
    chk("l2_err", 1, 32'(rsp_err[1]), 32'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_data", 1, rsp_data[1], 32'h0000_0093);
      chk("bp_valid", 1, 32'(rsp_valid[1]), 32'd1);
      chk("bp_req_ready", 1, 32'(req_ready[1]), 32'd0);
      chk("bp_busy", 1, 32'(busy[1]), 32'd1);
    end
    rsp_ready = 1'b1;
    tick();
    for (int i = 0; i < NInst; i++) chk("bp_release", i, 32'(busy[i]), 32'd0);

    fetch_check("pc0", Base, 32'h0000_0093, 1'b0, 1'b0, 32'h0, 32'h0);
    fetch_check("pc4", Base + 32'd4, 32'hA500_0001, 1'b0, 1'b0, 32'h0, 32'h0);
    fetch_check("pc8", Base + 32'd8, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 32'h0);
    fetch_check("last", Base + 32'h0FFC, 32'h5A5A_0FFC, 1'b0, 1'b0, 32'h0, 32'h0);
    fetch_check("misalign", Base + 32'd2, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    fetch_check("above", Base + 32'h1000, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    fetch_check("below", 32'h00FF_FFFC, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    fetch_check("collide", Base + 32'd8, 32'h1111_1111, 1'b0, 1'b1, Base + 32'd8, 32'h2222_2222);
    fetch_check("post_load", Base + 32'd8, 32'h2222_2222, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset with requests in flight: nothing may ever be answered for them.
    wait_idle();
    req_valid = 1'b1;
    req_addr  = Base + 32'd4;
    tick();
    req_valid = 1'b0;
    reset     = 1'b0;
    #1;
    for (int i = 0; i < NInst; i++) begin
      chk("rst_mid_valid", i, 32'(rsp_valid[i]), 32'd0);
      chk("rst_mid_busy", i, 32'(busy[i]), 32'd0);
    end
    tick();
    reset = 1'b1;
    repeat (6) begin
      tick();
      for (int i = 0; i < NInst; i++) chk("rst_no_rsp", i, 32'(rsp_valid[i]), 32'd0);
    end
    fetch_check("mem_intact", Base, 32'h0000_0093, 1'b0, 1'b0, 32'h0, 32'h0);

    // Random traffic: fetches, backpressure, loads and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset     = ($urandom_range(0, 199) != 0);
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = rand_fetch_addr();
      rsp_ready = ($urandom_range(0, 9) < 6);
      load_en   = reset && ($urandom_range(0, 9) == 0);
      load_addr = rand_fetch_addr();
      load_data = $urandom;
    end
    tick();
    reset     = 1'b1;
    req_valid = 1'b0;
    load_en   = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
